// File: rtl/dmux_cdc_pkg.sv
// rtl/dmux_cdc_pkg.sv - shared types and helpers for the mux-based multi-bit CDC path
//
// Holds the launcher FSM state encoding, the default word width and the
// helper that sizes the shared phase counter.

package dmux_cdc_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HOLD       = 3'd1,
    WAIT_ACK_H = 3'd2,
    WAIT_ACK_L = 3'd3,
    GAP        = 3'd4
  } tx_state_e;

  // One counter serves every timed phase, so it must hold the largest
  // terminal count of the three.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles,
                                   input int timeout_cycles);
    int m;
    m = hold_cycles;
    if (gap_cycles > m) m = gap_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// rtl/cdc_sync_bit.sv - multi-flop synchronizer for one asynchronous level
//
// Ports:
//   clk  in   destination-domain clock
//   rst  in   asynchronous active-high reset, clears the chain to 0
//   d    in   asynchronous level to be synchronized
//   q    out  last stage of the chain

module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dmux_cdc_tx.sv
// rtl/dmux_cdc_tx.sv - source-side launcher driving the data/valid pair of dmux_cdc
//
// Ports:
//   clk_f        in   source (fast) clock
//   rst          in   asynchronous active-high reset
//   src_data     in   word to send
//   src_valid    in   src_data valid
//   src_ready    out  block can accept (combinational, IDLE only)
//   data_out     out  registered word to dmux_cdc data_in
//   valid_out    out  registered qualifier to dmux_cdc valid_in
//   ack_in       in   level acknowledge from the slow domain (asynchronous)
//   done         out  one-cycle pulse on normal completion
//   err_timeout  out  one-cycle pulse when an ack phase times out
//   busy         out  high whenever the FSM is not IDLE

module dmux_cdc_tx
  import dmux_cdc_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int HOLD_CYCLES    = 10,
  parameter int GAP_CYCLES     = 4,
  parameter bit ACK_EN         = 1'b1,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_f,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ack_in,
  output logic                  done,
  output logic                  err_timeout,
  output logic                  busy
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);

  // Terminal counts: the counter is cleared on entry, so a phase of N
  // cycles ends on the edge where it reads N-1.
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  // A zero-length gap skips the GAP state entirely.
  localparam tx_state_e AFTER_XFER = (GAP_CYCLES == 0) ? IDLE : GAP;

  tx_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  valid_d;
  logic                  done_d;
  logic                  err_d;
  logic                  ack_sync;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk_f),
    .rst (rst),
    .d   (ack_in),
    .q   (ack_sync)
  );

  always_ff @(posedge clk_f or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_out    <= data_d;
      valid_out   <= valid_d;
      done        <= done_d;
      err_timeout <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    data_d  = data_out;
    valid_d = valid_out;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (src_valid) begin
          data_d  = src_data;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (!ACK_EN) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = AFTER_XFER;
          end else if (ack_sync) begin
            // Ack already up: the slow side has the word, drop valid now.
            valid_d = 1'b0;
            state_d = WAIT_ACK_L;
          end else begin
            state_d = WAIT_ACK_H;
          end
        end
      end

      WAIT_ACK_H: begin
        // An ack arriving on the timeout edge still wins.
        if (ack_sync) begin
          cnt_d   = '0;
          valid_d = 1'b0;
          state_d = WAIT_ACK_L;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d   = '0;
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = AFTER_XFER;
        end
      end

      WAIT_ACK_L: begin
        if (!ack_sync) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = AFTER_XFER;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = AFTER_XFER;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign src_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/dmux_cdc_tx.md
Name: dmux_cdc_tx

Overview:
- Source-side launcher for the mux-based multi-bit CDC path.
- Accepts words from fast-domain logic on a valid/ready handshake and drives the data/valid pair consumed by dmux_cdc.
- Holds data stable and valid asserted long enough for the slow domain to sample it, then enforces a guard gap.
- Optionally runs a 4-phase req/ack handshake against an acknowledge returned from the slow domain; single clock domain (clk_f).

Parameters:
- DATA_WIDTH, 8, width of the transferred word.
- HOLD_CYCLES, 10, minimum clk_f cycles valid_out stays high; must be >= 1.
- GAP_CYCLES, 4, clk_f cycles valid_out stays low after a transfer before the next accept; 0 allowed.
- ACK_EN, 1, 1 = wait on ack_in (4-phase); 0 = purely timed (hold then gap).
- SYNC_STAGES, 2, flops in the ack_in synchronizer; must be >= 2.
- TIMEOUT_CYCLES, 255, max cycles waiting in either ack phase before abort.

Ports:
- clk_f  in  1  source (fast) clock.
- rst  in  1  asynchronous, active-high reset.
- src_data  in  DATA_WIDTH  word to send.
- src_valid  in  1  src_data valid.
- src_ready  out  1  block can accept; combinational, high only in IDLE.
- data_out  out  DATA_WIDTH  registered word to dmux_cdc data_in.
- valid_out  out  1  registered qualifier to dmux_cdc valid_in.
- ack_in  in  1  level ack from slow domain, asynchronous to clk_f; ignored when ACK_EN=0.
- done  out  1  one-cycle pulse when a transfer completes normally.
- err_timeout  out  1  one-cycle pulse on ack timeout.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values (async, immediate on rst=1): data_out=0, valid_out=0, done=0, err_timeout=0, state=IDLE, counter=0, sync chain=0.
- Reset mid-transfer aborts it. No done pulse, and valid_out drops in the same instant.
- ack_sync is the last stage of the SYNC_STAGES chain on ack_in. All ack decisions use ack_sync only.
- One counter, width clog2(max(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)+1). Cleared on every state entry.
- IDLE:
  - src_ready=1.
  - On src_valid=1 at posedge: data_out<=src_data, valid_out<=1, go to HOLD.
  - Accept-to-valid_out latency is 1 cycle.
- HOLD:
  - valid_out=1; data_out frozen.
  - After exactly HOLD_CYCLES cycles with valid_out high:
    - ACK_EN=0: valid_out<=0, done pulse, go to GAP.
    - ACK_EN=1 and ack_sync=1: valid_out<=0, go to WAIT_ACK_L.
    - ACK_EN=1 and ack_sync=0: go to WAIT_ACK_H.
- WAIT_ACK_H:
  - valid_out=1.
  - ack_sync=1: valid_out<=0, go to WAIT_ACK_L.
  - Counter reaches TIMEOUT_CYCLES: valid_out<=0, err_timeout pulse, go to GAP.
- WAIT_ACK_L:
  - valid_out=0.
  - ack_sync=0: done pulse, go to GAP.
  - Timeout: err_timeout pulse, go to GAP.
- GAP:
  - valid_out=0; data_out holds the last word; no data_out change outside IDLE accept.
  - After GAP_CYCLES cycles, go to IDLE.
  - GAP_CYCLES=0: GAP lasts 0 cycles and the FSM goes to IDLE on the same edge as the GAP entry decision.
- src_valid outside IDLE is ignored; the source must hold it (standard valid/ready).
- Back-to-back accepts are spaced by at least HOLD_CYCLES + max(GAP_CYCLES, 1) cycles.
- done and err_timeout are never high together.

Decomposition:
- Shared package dmux_cdc_pkg holds:
  - FSM state enum (IDLE, HOLD, WAIT_ACK_H, WAIT_ACK_L, GAP);
  - default DATA_WIDTH;
  - a counter-width function.
- Sub-module cdc_sync_bit: SYNC_STAGES flop chain with async active-high reset to 0. Reusable by dmux_cdc.

Test Plan:
- Reset: rst=1 during src_valid=1 with src_data=8'hA5 -> data_out=0, valid_out=0, src_ready=1 after release. Second rst pulse mid-HOLD -> valid_out falls immediately, no done.
- Timed mode (ACK_EN=0, HOLD=10, GAP=4): send 8'h3C -> valid_out high exactly 10 cycles starting 1 cycle after accept; done 1 cycle at the falling edge; src_ready back after 4 gap cycles; data_out stays 8'h3C throughout.
- Timed back-to-back: src_valid held high with words 8'h11, 8'h22, 8'h33 -> accepts spaced exactly 15 cycles; each valid_out window 10 cycles; data never changes while valid_out=1.
- Ack mode: ack_in rises 20 cycles after accept and falls 5 cycles after valid_out drops -> valid_out drops 2 cycles after the ack_in rise; done fires 2 cycles after the ack_in fall; then GAP, then IDLE.
- Early ack: ack_in already high before HOLD ends -> valid_out still high the full 10 cycles, then drops; FSM goes straight to WAIT_ACK_L.
- Timeout (TIMEOUT_CYCLES=16): ack_in stuck 0 -> valid_out drops after 10+16 cycles, err_timeout pulses once, no done, FSM returns to IDLE after the gap.
